// File: rtl/uart_batch_receiver.sv
// UART batch receiver: 16x-oversampled bytes packed into one word; define UART_BATCH_TIMEOUT_EN to drop stale partial batches.
// Latency: batch_valid 1 clk after the final stop sample (+2 clk rx sync); backpressure: word held until batch_ack, a completion while held sets overrun.
module uart_batch_receiver #(
    parameter int DBITS       = 8,
    parameter int SB_TICK     = 16,
    parameter int BATCH_BYTES = 4,
    parameter int TIMEOUT_TK  = 512
) (
    input  logic                             clk_100MHz,
    input  logic                             reset_n,
    input  logic                             rx,
    input  logic                             sample_tick,
    output logic [DBITS*BATCH_BYTES-1:0]     batch_data,
    output logic                             batch_valid,
    input  logic                             batch_ack,
    output logic [$clog2(BATCH_BYTES+1)-1:0] byte_count,
    output logic                             frame_error,
    output logic                             overrun
);

    localparam int WW = DBITS * BATCH_BYTES;
    localparam int CW = $clog2(BATCH_BYTES + 1);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_sync_q, rx_sync_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBITS-1:0] shreg_q, shreg_d;
    logic [WW-1:0]   buf_q, buf_d;
    logic [WW-1:0]   word_q, word_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fe_q, fe_d;
    logic            ovr_q, ovr_d;
    logic            byte_ok;
    logic            start_entry;

`ifdef UART_BATCH_TIMEOUT_EN
    localparam int TW = (TIMEOUT_TK > 1) ? $clog2(TIMEOUT_TK) : 1;
    logic [TW-1:0]   idle_q, idle_d;
`else
    logic            unused_timeout;
    assign unused_timeout = |TIMEOUT_TK;
`endif

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            s_q       <= '0;
            n_q       <= '0;
            shreg_q   <= '0;
            buf_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_BATCH_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            s_q       <= s_d;
            n_q       <= n_d;
            shreg_q   <= shreg_d;
            buf_q     <= buf_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
`ifdef UART_BATCH_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        s_d         = s_q;
        n_d         = n_q;
        shreg_d     = shreg_q;
        buf_d       = buf_q;
        word_d      = word_q;
        valid_d     = valid_q;
        count_d     = count_q;
        fe_d        = 1'b0;
        ovr_d       = ovr_q;
        byte_ok     = 1'b0;
        start_entry = 1'b0;
`ifdef UART_BATCH_TIMEOUT_EN
        idle_d      = idle_q;
`endif

        if (valid_q && batch_ack) begin
            valid_d = 1'b0;
        end

        if (sample_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_sync_q) begin
                        state_d     = S_START;
                        s_d         = '0;
                        start_entry = 1'b1;
                    end
                end
                S_START: begin
                    if (s_q == SW'(7)) begin
                        if (!rx_sync_q) begin
                            state_d = S_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
                S_DATA: begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        shreg_d = {rx_sync_q, shreg_q[DBITS-1:1]};
                        if (n_q == NW'(DBITS - 1)) begin
                            state_d = S_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
                S_STOP: begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = S_IDLE;
                        s_d     = '0;
                        if (rx_sync_q) begin
                            byte_ok = 1'b1;
                        end else begin
                            fe_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Slot 0 is the MS byte; the completed word includes the byte landing this cycle.
        if (byte_ok) begin
            for (int k = 0; k < BATCH_BYTES; k++) begin
                if (count_q == CW'(k)) begin
                    buf_d[(BATCH_BYTES-1-k)*DBITS +: DBITS] = shreg_q;
                end
            end
            if (count_q == CW'(BATCH_BYTES - 1)) begin
                count_d = '0;
                if (!valid_q || batch_ack) begin
                    word_d  = buf_d;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                count_d = count_q + CW'(1);
            end
        end

`ifdef UART_BATCH_TIMEOUT_EN
        if (start_entry || (count_q == '0)) begin
            idle_d = '0;
        end else if (sample_tick && (state_q == S_IDLE)) begin
            if (idle_q == TW'(TIMEOUT_TK - 1)) begin
                idle_d  = '0;
                count_d = '0;
                fe_d    = 1'b1;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
`endif
    end

    assign batch_data  = word_q;
    assign batch_valid = valid_q;
    assign byte_count  = count_q;
    assign frame_error = fe_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_batch_receiver.sv
// Scoreboard bench for uart_batch_receiver: expected words queued at send time, checked as the DUT presents them.
module tb_uart_batch_receiver;

    logic        clk_100MHz = 1'b0;
    logic        reset_n;
    logic        rx;
    logic        sample_tick;
    logic [31:0] batch_data;
    logic        batch_valid;
    logic        batch_ack;
    logic [2:0]  byte_count;
    logic        frame_error;
    logic        overrun;

    int          total = 0;
    int          bad   = 0;
    int          fe_cnt = 0;
    int          fe_before;
    logic [31:0] exp_q[$];
    logic        vld_prev = 1'b0;
    logic        ack_prev = 1'b0;

    uart_batch_receiver dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .rx         (rx),
        .sample_tick(sample_tick),
        .batch_data (batch_data),
        .batch_valid(batch_valid),
        .batch_ack  (batch_ack),
        .byte_count (byte_count),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // A new word is on the outputs when valid rises, or stays up right after an accepted ack.
    always @(negedge clk_100MHz) begin
        if (batch_valid && (!vld_prev || ack_prev)) begin
            if (exp_q.size() == 0) begin
                chk("sb_queue", exp_q.size(), 1);
            end else begin
                chk("sb_word", batch_data, exp_q.pop_front());
            end
        end
        if (frame_error) fe_cnt++;
        vld_prev = batch_valid;
        ack_prev = batch_ack;
    end

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic check_zero(input string pfx);
        @(negedge clk_100MHz);
        chk({pfx, "_data"},  batch_data,  32'h0);
        chk({pfx, "_valid"}, batch_valid, 1'b0);
        chk({pfx, "_count"}, byte_count,  3'd0);
        chk({pfx, "_fe"},    frame_error, 1'b0);
        chk({pfx, "_ovr"},   overrun,     1'b0);
    endtask

    task automatic do_reset();
        rx        = 1'b1;
        batch_ack = 1'b0;
        reset_n   = 1'b0;
        repeat (3) tick();
        check_zero("rst");
        reset_n = 1'b1;
        tick();
    endtask

    // Stop-bit phase: ack (if requested) is high exactly at the DUT's stop-sample edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic ack_done);
        rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) tick();
        end
        rx = stop_ok;
        repeat (10) tick();
        if (ack_done) batch_ack = 1'b1;
        tick();
        batch_ack = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_batch(input logic [31:0] w, input logic ack_last);
        for (int j = 0; j < 4; j++) begin
            send_byte(w[31-8*j -: 8], 1'b1, ack_last && (j == 3));
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk_100MHz);
        batch_ack = 1'b1;
        @(posedge clk_100MHz);
        #1;
        batch_ack = 1'b0;
        @(negedge clk_100MHz);
        chk("ack_clr", batch_valid, 1'b0);
    endtask

    initial begin
        reset_n     = 1'b0;
        rx          = 1'b1;
        sample_tick = 1'b1;
        batch_ack   = 1'b0;
        do_reset();

        // basic batch and handshake
        exp_q.push_back(32'h12345678);
        send_batch(32'h12345678, 1'b0);
        @(negedge clk_100MHz);
        chk("t1_valid", batch_valid, 1'b1);
        chk("t1_data",  batch_data,  32'h12345678);
        chk("t1_count", byte_count,  3'd0);
        ack_pulse();

        // false start
        fe_before = fe_cnt;
        rx = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
        repeat (30) tick();
        @(negedge clk_100MHz);
        chk("t2_count", byte_count, 3'd0);
        chk("t2_fe",    fe_cnt - fe_before, 0);
        chk("t2_valid", batch_valid, 1'b0);

        // framing error then a good batch
        fe_before = fe_cnt;
        send_byte(8'hA5, 1'b0, 1'b0);
        repeat (40) tick();
        @(negedge clk_100MHz);
        chk("t3_count_fe", byte_count, 3'd0);
        exp_q.push_back(32'hCAFEF00D);
        send_batch(32'hCAFEF00D, 1'b0);
        @(negedge clk_100MHz);
        chk("t3_fe",    fe_cnt - fe_before, 1);
        chk("t3_valid", batch_valid, 1'b1);
        ack_pulse();

        // overrun: second batch completes while first is still held
        do_reset();
        exp_q.push_back(32'h11223344);
        send_batch(32'h11223344, 1'b0);
        send_batch(32'h55667788, 1'b0);
        @(negedge clk_100MHz);
        chk("t4_ovr",   overrun,     1'b1);
        chk("t4_data",  batch_data,  32'h11223344);
        chk("t4_valid", batch_valid, 1'b1);
        chk("t4_count", byte_count,  3'd0);
        do_reset();

        // ack on the completion clock: new word loads, no overrun
        exp_q.push_back(32'h11223344);
        send_batch(32'h11223344, 1'b0);
        exp_q.push_back(32'h99AABBCC);
        send_batch(32'h99AABBCC, 1'b1);
        @(negedge clk_100MHz);
        chk("t4b_valid", batch_valid, 1'b1);
        chk("t4b_data",  batch_data,  32'h99AABBCC);
        chk("t4b_ovr",   overrun,     1'b0);
        ack_pulse();

        // reset during data bits of byte 3
        send_byte(8'hDE, 1'b1, 1'b0);
        send_byte(8'hAD, 1'b1, 1'b0);
        @(negedge clk_100MHz);
        chk("t5_count2", byte_count, 3'd2);
        rx = 1'b0;
        repeat (16) tick();
        rx = 1'b1;
        repeat (40) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        check_zero("t5");
        reset_n = 1'b1;
        repeat (20) tick();
        exp_q.push_back(32'h0F1E2D3C);
        send_batch(32'h0F1E2D3C, 1'b0);
        @(negedge clk_100MHz);
        chk("t5_valid", batch_valid, 1'b1);
        chk("t5_count", byte_count,  3'd0);
        ack_pulse();

        // partial batch left idle
        fe_before = fe_cnt;
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        @(negedge clk_100MHz);
        chk("t6_count_pre", byte_count, 3'd2);
        repeat (540) tick();
        @(negedge clk_100MHz);
`ifdef UART_BATCH_TIMEOUT_EN
        chk("t6_count", byte_count, 3'd0);
        chk("t6_fe",    fe_cnt - fe_before, 1);
`else
        chk("t6_count", byte_count, 3'd2);
        chk("t6_fe",    fe_cnt - fe_before, 0);
`endif

        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
